// File: rtl/imem_boot_controller.sv
// ---------------------------------------------------------------------------
// imem_boot_controller
//
// Boot sequencer for a single-cycle CPU's instruction memory. It takes a
// program streamed in from the host loader, writes it word by word into
// instruction memory, restarts the CPU at word 0, and lets it run. The run
// stops when the CPU fetches its terminating jump-to-self, or when the run
// reaches MAX_CYCLES.
//
// Parameters
//   ADDR_WIDTH  instruction-memory word-address bits (2^ADDR_WIDTH words)
//   MAX_CYCLES  number of RUN cycles allowed before a forced halt
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   Load_Start   one-cycle request to begin a new program load
//   Load_Valid   Load_Data carries a word this cycle
//   Load_Data    instruction word from the host
//   Load_Last    marks the final word of the program
//   Load_Ready   controller accepts a word this cycle
//   Mem_WE       instruction-memory write enable
//   Mem_WAddr    word address of the write
//   Mem_WData    write data
//   Fetch_PC     CPU current PC
//   Fetch_Instr  instruction read at Fetch_PC
//   Cpu_Restart  one-cycle pulse telling the CPU to clear its PC to 0
//   Cpu_Run      CPU may advance its PC and commit; 0 holds it
//   Halted       program reached jump-to-self or timed out
//   Timeout      the halt was caused by the MAX_CYCLES limit
//   Load_Error   program did not fit in instruction memory
//   Cycle_Count  RUN cycles of the last or current run
// ---------------------------------------------------------------------------
module imem_boot_controller #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] MAX_CYCLES = 32'd100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Load_Start,
    input  logic                  Load_Valid,
    input  logic [31:0]           Load_Data,
    input  logic                  Load_Last,
    output logic                  Load_Ready,
    output logic                  Mem_WE,
    output logic [ADDR_WIDTH-1:0] Mem_WAddr,
    output logic [31:0]           Mem_WData,
    input  logic [31:0]           Fetch_PC,
    input  logic [31:0]           Fetch_Instr,
    output logic                  Cpu_Restart,
    output logic                  Cpu_Run,
    output logic                  Halted,
    output logic                  Timeout,
    output logic                  Load_Error,
    output logic [31:0]           Cycle_Count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        HALT
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] ptr_next;

    logic                  load_ready_next;
    logic                  mem_we_next;
    logic [ADDR_WIDTH-1:0] mem_waddr_next;
    logic [31:0]           mem_wdata_next;
    logic                  cpu_restart_next;
    logic                  cpu_run_next;
    logic                  halted_next;
    logic                  timeout_next;
    logic                  load_error_next;
    logic [31:0]           cycle_count_next;

    logic                  handshake;
    logic                  halt_detect;
    logic                  ptr_at_top;
    logic                  count_at_limit;

    // PC bits outside the J-type target field play no part in halt detection.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{Fetch_PC[31:28], Fetch_PC[1:0]};

    // Load_Ready is a register that is high exactly while in LOAD, so it can
    // be used directly to qualify the handshake.
    assign handshake      = Load_Valid & Load_Ready;

    // A jump (opcode 000010) whose target equals the current PC never moves.
    assign halt_detect    = (Fetch_Instr[31:26] == 6'b000010) &&
                            (Fetch_Instr[25:0] == Fetch_PC[27:2]);

    assign ptr_at_top     = (ptr == {ADDR_WIDTH{1'b1}});

    // Cycle_Count still holds the count of previous RUN cycles, so the
    // current cycle is the last allowed one when it equals MAX_CYCLES-1.
    assign count_at_limit = (Cycle_Count == (MAX_CYCLES - 32'd1));

    // State, write pointer and every output are registers updated together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            Load_Ready  <= 1'b0;
            Mem_WE      <= 1'b0;
            Mem_WAddr   <= '0;
            Mem_WData   <= '0;
            Cpu_Restart <= 1'b0;
            Cpu_Run     <= 1'b0;
            Halted      <= 1'b0;
            Timeout     <= 1'b0;
            Load_Error  <= 1'b0;
            Cycle_Count <= '0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            Load_Ready  <= load_ready_next;
            Mem_WE      <= mem_we_next;
            Mem_WAddr   <= mem_waddr_next;
            Mem_WData   <= mem_wdata_next;
            Cpu_Restart <= cpu_restart_next;
            Cpu_Run     <= cpu_run_next;
            Halted      <= halted_next;
            Timeout     <= timeout_next;
            Load_Error  <= load_error_next;
            Cycle_Count <= cycle_count_next;
        end
    end

    // Next state and next register values. Status flags, write address/data
    // and the cycle count hold by default; strobes default low.
    always_comb begin
        state_next       = state;
        ptr_next         = ptr;
        load_ready_next  = 1'b0;
        mem_we_next      = 1'b0;
        mem_waddr_next   = Mem_WAddr;
        mem_wdata_next   = Mem_WData;
        cpu_restart_next = 1'b0;
        cpu_run_next     = 1'b0;
        halted_next      = Halted;
        timeout_next     = Timeout;
        load_error_next  = Load_Error;
        cycle_count_next = Cycle_Count;

        unique case (state)
            IDLE: begin
                ptr_next = '0;
                if (Load_Start) begin
                    state_next      = LOAD;
                    load_ready_next = 1'b1;
                    halted_next     = 1'b0;
                    timeout_next    = 1'b0;
                    load_error_next = 1'b0;
                end
            end

            LOAD: begin
                load_ready_next = 1'b1;
                if (handshake) begin
                    mem_we_next    = 1'b1;
                    mem_waddr_next = ptr;
                    mem_wdata_next = Load_Data;
                    ptr_next       = ptr + ADDR_WIDTH'(1);
                    if (Load_Last) begin
                        state_next      = START;
                        load_ready_next = 1'b0;
                    end else if (ptr_at_top) begin
                        // The top word is still written, but the program is
                        // incomplete, so the CPU is never started.
                        state_next      = IDLE;
                        load_ready_next = 1'b0;
                        load_error_next = 1'b1;
                    end
                end
            end

            // START spans two cycles: the first overlaps the final memory
            // write, the second carries the Cpu_Restart pulse. The pulse
            // register itself tells the two cycles apart.
            START: begin
                cycle_count_next = '0;
                if (!Cpu_Restart) begin
                    cpu_restart_next = 1'b1;
                end else begin
                    cpu_run_next = 1'b1;
                    state_next   = RUN;
                end
            end

            RUN: begin
                cpu_run_next = 1'b1;
                if (Cycle_Count != 32'hFFFF_FFFF) begin
                    cycle_count_next = Cycle_Count + 32'd1;
                end
                // Halt detection takes priority over the cycle limit.
                if (halt_detect) begin
                    state_next   = HALT;
                    cpu_run_next = 1'b0;
                    halted_next  = 1'b1;
                end else if (count_at_limit) begin
                    state_next   = HALT;
                    cpu_run_next = 1'b0;
                    halted_next  = 1'b1;
                    timeout_next = 1'b1;
                end
            end

            // Cycle_Count stays visible here until the next START clears it.
            HALT: begin
                if (Load_Start) begin
                    state_next      = LOAD;
                    ptr_next        = '0;
                    load_ready_next = 1'b1;
                    halted_next     = 1'b0;
                    timeout_next    = 1'b0;
                    load_error_next = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_boot_controller.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_controller
//
// Directed testbench for imem_boot_controller. Three instances share the
// same stimulus: a default-sized one (main), one with MAX_CYCLES=16 (to) and
// one with ADDR_WIDTH=2 (small). Each scenario starts from reset and checks
// only the instance it targets.
// ---------------------------------------------------------------------------
module tb_imem_boot_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic [31:0] fetch_instr = '0;

    logic        m_load_ready, m_mem_we, m_cpu_restart, m_cpu_run;
    logic        m_halted, m_timeout, m_load_error;
    logic [7:0]  m_mem_waddr;
    logic [31:0] m_mem_wdata, m_cycle_count;

    logic        t_load_ready, t_mem_we, t_cpu_restart, t_cpu_run;
    logic        t_halted, t_timeout, t_load_error;
    logic [7:0]  t_mem_waddr;
    logic [31:0] t_mem_wdata, t_cycle_count;

    logic        s_load_ready, s_mem_we, s_cpu_restart, s_cpu_run;
    logic        s_halted, s_timeout, s_load_error;
    logic [1:0]  s_mem_waddr;
    logic [31:0] s_mem_wdata, s_cycle_count;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] HALT_PC    = 32'h0040_0068;
    localparam logic [31:0] HALT_INSTR = 32'h0810_001a;
    localparam logic [31:0] NEAR_INSTR = 32'h0810_0019;

    always #5 clk = ~clk;

    imem_boot_controller dut_main (
        .clk(clk), .reset(reset),
        .Load_Start(load_start), .Load_Valid(load_valid),
        .Load_Data(load_data), .Load_Last(load_last),
        .Load_Ready(m_load_ready), .Mem_WE(m_mem_we),
        .Mem_WAddr(m_mem_waddr), .Mem_WData(m_mem_wdata),
        .Fetch_PC(fetch_pc), .Fetch_Instr(fetch_instr),
        .Cpu_Restart(m_cpu_restart), .Cpu_Run(m_cpu_run),
        .Halted(m_halted), .Timeout(m_timeout),
        .Load_Error(m_load_error), .Cycle_Count(m_cycle_count)
    );

    imem_boot_controller #(.ADDR_WIDTH(8), .MAX_CYCLES(32'd16)) dut_to (
        .clk(clk), .reset(reset),
        .Load_Start(load_start), .Load_Valid(load_valid),
        .Load_Data(load_data), .Load_Last(load_last),
        .Load_Ready(t_load_ready), .Mem_WE(t_mem_we),
        .Mem_WAddr(t_mem_waddr), .Mem_WData(t_mem_wdata),
        .Fetch_PC(fetch_pc), .Fetch_Instr(fetch_instr),
        .Cpu_Restart(t_cpu_restart), .Cpu_Run(t_cpu_run),
        .Halted(t_halted), .Timeout(t_timeout),
        .Load_Error(t_load_error), .Cycle_Count(t_cycle_count)
    );

    imem_boot_controller #(.ADDR_WIDTH(2), .MAX_CYCLES(32'd100000)) dut_small (
        .clk(clk), .reset(reset),
        .Load_Start(load_start), .Load_Valid(load_valid),
        .Load_Data(load_data), .Load_Last(load_last),
        .Load_Ready(s_load_ready), .Mem_WE(s_mem_we),
        .Mem_WAddr(s_mem_waddr), .Mem_WData(s_mem_wdata),
        .Fetch_PC(fetch_pc), .Fetch_Instr(fetch_instr),
        .Cpu_Restart(s_cpu_restart), .Cpu_Run(s_cpu_run),
        .Halted(s_halted), .Timeout(s_timeout),
        .Load_Error(s_load_error), .Cycle_Count(s_cycle_count)
    );

    // Program image used by the 27-word load: word 26 is the jump-to-self.
    function automatic logic [31:0] prog_word(input int i);
        if (i == 26) return HALT_INSTR;
        return 32'h2000_0000 | 32'(i);
    endfunction

    task automatic do_reset();
        reset       = 1'b0;
        load_start  = 1'b0;
        load_valid  = 1'b0;
        load_last   = 1'b0;
        load_data   = '0;
        fetch_pc    = HALT_PC;
        fetch_instr = NEAR_INSTR;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Streams n back-to-back words, Last on the final one; returns on the
    // negedge after the final handshake.
    task automatic load_program(input int n);
        pulse_start();
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = 32'h1000_0000 | 32'(i);
            load_last  = (i == n - 1);
            @(negedge clk);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        checks++;
        if ({m_load_ready, m_mem_we, m_mem_waddr, m_mem_wdata, m_cpu_restart, m_cpu_run,
             m_halted, m_timeout, m_load_error, m_cycle_count} !== '0) begin
            errors++;
            $display("FAIL reset_values: ready=%b we=%b waddr=%h wdata=%h rst=%b run=%b hlt=%b to=%b err=%b cnt=%0d, required all 0",
                     m_load_ready, m_mem_we, m_mem_waddr, m_mem_wdata, m_cpu_restart, m_cpu_run,
                     m_halted, m_timeout, m_load_error, m_cycle_count);
        end
        do_reset();
    endtask

    task automatic test_load_and_run();
        do_reset();
        pulse_start();
        checks++;
        if (m_load_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready_rise: got %b, required 1", m_load_ready);
        end
        load_valid = 1'b1;
        load_data  = prog_word(0);
        load_last  = 1'b0;
        for (int i = 1; i <= 27; i++) begin
            @(negedge clk);
            checks++;
            if ({m_mem_we, m_mem_waddr, m_mem_wdata, m_cpu_restart} !==
                {1'b1, 8'(i - 1), prog_word(i - 1), 1'b0}) begin
                errors++;
                $display("FAIL write_word_%0d: we=%b addr=%0d data=%h restart=%b, required we=1 addr=%0d data=%h restart=0",
                         i - 1, m_mem_we, m_mem_waddr, m_mem_wdata, m_cpu_restart, i - 1, prog_word(i - 1));
            end
            if (i < 27) begin
                load_data = prog_word(i);
                load_last = (i == 26);
            end else begin
                load_valid = 1'b0;
                load_last  = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if ({m_cpu_restart, m_cpu_run, m_mem_we, m_load_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL restart_pulse: restart=%b run=%b we=%b ready=%b, required 1 0 0 0",
                     m_cpu_restart, m_cpu_run, m_mem_we, m_load_ready);
        end
        @(negedge clk);
        checks++;
        if ({m_cpu_restart, m_cpu_run, m_cycle_count} !== {2'b01, 32'd0}) begin
            errors++;
            $display("FAIL run_start: restart=%b run=%b cnt=%0d, required 0 1 0",
                     m_cpu_restart, m_cpu_run, m_cycle_count);
        end
        // Now in RUN cycle 1; advance to RUN cycle 40 with the near-miss jump.
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
        end
        checks++;
        if ({m_halted, m_cpu_run, m_cycle_count} !== {2'b01, 32'd39}) begin
            errors++;
            $display("FAIL no_halt_near_jump: halted=%b run=%b cnt=%0d, required 0 1 39",
                     m_halted, m_cpu_run, m_cycle_count);
        end
        fetch_instr = HALT_INSTR;
        @(negedge clk);
        fetch_instr = NEAR_INSTR;
        checks++;
        if ({m_halted, m_cpu_run, m_timeout, m_cycle_count} !== {3'b100, 32'd40}) begin
            errors++;
            $display("FAIL halt_detect: halted=%b run=%b timeout=%b cnt=%0d, required 1 0 0 40",
                     m_halted, m_cpu_run, m_timeout, m_cycle_count);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({m_halted, m_cycle_count} !== {1'b1, 32'd40}) begin
            errors++;
            $display("FAIL halt_frozen: halted=%b cnt=%0d, required 1 40", m_halted, m_cycle_count);
        end
    endtask

    task automatic test_timeout();
        int wait_cycles;
        int runs;
        do_reset();
        load_program(2);
        wait_cycles = 0;
        while (!t_cpu_run && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        checks++;
        if (t_cpu_run !== 1'b1) begin
            errors++;
            $display("FAIL timeout_run_start: run=%b after %0d cycles, required 1", t_cpu_run, wait_cycles);
        end
        runs = 0;
        while (t_cpu_run && runs < 100) begin
            runs++;
            @(negedge clk);
        end
        checks++;
        if (runs != 16) begin
            errors++;
            $display("FAIL timeout_run_length: got %0d run cycles, required 16", runs);
        end
        checks++;
        if ({t_halted, t_timeout, t_cycle_count} !== {2'b11, 32'd16}) begin
            errors++;
            $display("FAIL timeout_status: halted=%b timeout=%b cnt=%0d, required 1 1 16",
                     t_halted, t_timeout, t_cycle_count);
        end
        checks++;
        if ({m_halted, m_cpu_run} !== 2'b01) begin
            errors++;
            $display("FAIL main_still_running: halted=%b run=%b, required 0 1", m_halted, m_cpu_run);
        end
    endtask

    task automatic test_timeout_tie();
        int wait_cycles;
        do_reset();
        load_program(2);
        wait_cycles = 0;
        while (!t_cpu_run && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        repeat (15) @(negedge clk);
        checks++;
        if ({t_halted, t_cpu_run} !== 2'b01) begin
            errors++;
            $display("FAIL tie_before: halted=%b run=%b, required 0 1", t_halted, t_cpu_run);
        end
        fetch_instr = HALT_INSTR;
        @(negedge clk);
        fetch_instr = NEAR_INSTR;
        checks++;
        if ({t_halted, t_timeout, t_cpu_run, t_cycle_count} !== {3'b100, 32'd16}) begin
            errors++;
            $display("FAIL tie_halt_wins: halted=%b timeout=%b run=%b cnt=%0d, required 1 0 0 16",
                     t_halted, t_timeout, t_cpu_run, t_cycle_count);
        end
    endtask

    task automatic test_overflow();
        logic saw_restart;
        do_reset();
        pulse_start();
        load_valid = 1'b1;
        load_last  = 1'b0;
        load_data  = 32'hA000_0000;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i <= 4) begin
                checks++;
                if ({s_mem_we, s_mem_waddr, s_mem_wdata, s_load_ready, s_load_error} !==
                    {1'b1, 2'(i - 1), 32'hA000_0000 | 32'(i - 1), (i != 4), (i == 4)}) begin
                    errors++;
                    $display("FAIL overflow_write_%0d: we=%b addr=%0d data=%h ready=%b err=%b, required 1 %0d %h %b %b",
                             i - 1, s_mem_we, s_mem_waddr, s_mem_wdata, s_load_ready, s_load_error,
                             i - 1, 32'hA000_0000 | 32'(i - 1), (i != 4), (i == 4));
                end
            end
            if (i < 5) load_data = 32'hA000_0000 | 32'(i);
            else       load_valid = 1'b0;
        end
        checks++;
        if ({s_mem_we, s_load_ready, s_load_error} !== 3'b001) begin
            errors++;
            $display("FAIL overflow_fifth_word: we=%b ready=%b err=%b, required 0 0 1",
                     s_mem_we, s_load_ready, s_load_error);
        end
        saw_restart = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (s_cpu_restart) saw_restart = 1'b1;
        end
        checks++;
        if ({saw_restart, s_cpu_run, s_load_error, s_load_ready} !== 4'b0010) begin
            errors++;
            $display("FAIL overflow_idle: restart_seen=%b run=%b err=%b ready=%b, required 0 0 1 0",
                     saw_restart, s_cpu_run, s_load_error, s_load_ready);
        end
    endtask

    task automatic test_valid_toggle();
        logic [4:0] vpat;
        int         exp_ptr;
        int         wait_cycles;
        vpat    = 5'b10101;
        exp_ptr = 0;
        do_reset();
        pulse_start();
        load_valid = vpat[0];
        load_data  = 32'hC000_0000;
        load_last  = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++;
            if (m_mem_we !== vpat[i - 1] ||
                (vpat[i - 1] && (m_mem_waddr !== 8'(exp_ptr) ||
                                 m_mem_wdata !== (32'hC000_0000 | 32'(i - 1))))) begin
                errors++;
                $display("FAIL toggle_cycle_%0d: we=%b addr=%0d data=%h, required we=%b addr=%0d data=%h",
                         i - 1, m_mem_we, m_mem_waddr, m_mem_wdata, vpat[i - 1], exp_ptr,
                         32'hC000_0000 | 32'(i - 1));
            end
            if (vpat[i - 1]) exp_ptr++;
            if (i < 5) begin
                load_valid = vpat[i];
                load_data  = 32'hC000_0000 | 32'(i);
                load_last  = (i == 4);
            end else begin
                load_valid = 1'b0;
                load_last  = 1'b0;
            end
        end
        wait_cycles = 0;
        while (!m_cpu_run && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        load_start = 1'b1;
        load_valid = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        load_valid = 1'b0;
        checks++;
        if ({m_load_ready, m_cpu_run, m_mem_we} !== 3'b010) begin
            errors++;
            $display("FAIL start_in_run_ignored: ready=%b run=%b we=%b, required 0 1 0",
                     m_load_ready, m_cpu_run, m_mem_we);
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        pulse_start();
        load_valid = 1'b1;
        load_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_data = 32'hD000_0000 | 32'(i);
            @(negedge clk);
        end
        load_data = 32'hD000_0003;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({m_load_ready, m_mem_we, m_mem_waddr, m_mem_wdata, m_cpu_restart, m_cpu_run,
             m_halted, m_timeout, m_load_error, m_cycle_count} !== '0) begin
            errors++;
            $display("FAIL reset_mid_load: ready=%b we=%b waddr=%h wdata=%h rst=%b run=%b cnt=%0d, required all 0",
                     m_load_ready, m_mem_we, m_mem_waddr, m_mem_wdata, m_cpu_restart, m_cpu_run, m_cycle_count);
        end
        load_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({m_load_ready, m_cpu_run, m_cpu_restart, m_mem_we} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset: ready=%b run=%b restart=%b we=%b, required 0 0 0 0",
                     m_load_ready, m_cpu_run, m_cpu_restart, m_mem_we);
        end
        pulse_start();
        load_valid = 1'b1;
        load_last  = 1'b1;
        load_data  = 32'hE000_0000;
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
        checks++;
        if ({m_mem_we, m_mem_waddr, m_mem_wdata} !== {1'b1, 8'd0, 32'hE000_0000}) begin
            errors++;
            $display("FAIL reload_from_zero: we=%b addr=%0d data=%h, required 1 0 e0000000",
                     m_mem_we, m_mem_waddr, m_mem_wdata);
        end
    endtask

    initial begin
        test_reset();
        test_load_and_run();
        test_timeout();
        test_timeout_tie();
        test_overflow();
        test_valid_toggle();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
